// File: rtl/dr_memreq_tracker.sv
// Directory-to-memory request tracker: allocates DRIDs, forwards requests to memory,
// and turns out-of-order memory acks into L2 snacks. Optional macro DR_TRACKER_ERRCHK_EN.
module dr_memreq_tracker #(
  parameter int unsigned NUM_IDS = 64,
  parameter int unsigned ID_BITS = $clog2(NUM_IDS),
  parameter int unsigned PADDR_W = 49,
  parameter int unsigned CMD_W   = 3,
  parameter int unsigned NID_W   = 5,
  parameter int unsigned L2ID_W  = 6,
  parameter int unsigned SNACK_W = 5,
  parameter int unsigned LINE_W  = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_retry,
  input  logic [PADDR_W-1:0] req_paddr,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic [NID_W-1:0]   req_nid,
  input  logic [L2ID_W-1:0]  req_l2id,
  output logic               drtomem_req_valid,
  input  logic               drtomem_req_retry,
  output logic [PADDR_W-1:0] drtomem_req_paddr,
  output logic [CMD_W-1:0]   drtomem_req_cmd,
  output logic [ID_BITS-1:0] drtomem_req_drid,
  input  logic               memtodr_ack_valid,
  output logic               memtodr_ack_retry,
  input  logic [ID_BITS-1:0] memtodr_ack_drid,
  input  logic [SNACK_W-1:0] memtodr_ack_ack,
  input  logic [LINE_W-1:0]  memtodr_ack_line,
  output logic               drtol2_snack_valid,
  input  logic               drtol2_snack_retry,
  output logic [NID_W-1:0]   drtol2_snack_nid,
  output logic [L2ID_W-1:0]  drtol2_snack_l2id,
  output logic [ID_BITS-1:0] drtol2_snack_drid,
  output logic [SNACK_W-1:0] drtol2_snack_snack,
  output logic [LINE_W-1:0]  drtol2_snack_line,
  output logic [ID_BITS:0]   outstanding
`ifdef DR_TRACKER_ERRCHK_EN
  ,
  output logic               err_spurious_ack
`endif
);

  logic [NUM_IDS-1:0] r_free;
  logic [NUM_IDS-1:0] w_free_nxt;
  logic [NID_W-1:0]   r_nid_tbl  [NUM_IDS];
  logic [L2ID_W-1:0]  r_l2id_tbl [NUM_IDS];
  logic [ID_BITS-1:0] w_alloc_id;
  logic               w_any_free;
  logic               w_req_fire;
  logic               w_ack_fire;
  logic               w_ack_legal;
  logic               w_rel;

  // Lowest-index free DRID; bit 0 is reserved and never searched.
  always_comb begin
    w_alloc_id = '0;
    w_any_free = 1'b0;
    for (int i = int'(NUM_IDS) - 1; i >= 1; i--) begin
      if (r_free[i]) begin
        w_alloc_id = ID_BITS'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign req_retry         = !w_any_free || (drtomem_req_valid && drtomem_req_retry);
  assign w_req_fire        = req_valid && !req_retry;
  assign memtodr_ack_retry = drtol2_snack_valid && drtol2_snack_retry;
  assign w_ack_fire        = memtodr_ack_valid && !memtodr_ack_retry;

`ifdef DR_TRACKER_ERRCHK_EN
  assign w_ack_legal = (memtodr_ack_drid != '0) && !r_free[memtodr_ack_drid];
`else
  assign w_ack_legal = 1'b1;
`endif

  assign w_rel             = w_ack_fire && w_ack_legal;
  assign drtol2_snack_drid = '0;

  // A DRID released this cycle only becomes visible to allocation next cycle.
  always_comb begin
    w_free_nxt = r_free;
    if (w_req_fire) w_free_nxt[w_alloc_id] = 1'b0;
    if (w_rel)      w_free_nxt[memtodr_ack_drid] = 1'b1;
    w_free_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free      <= {{(NUM_IDS-1){1'b1}}, 1'b0};
      outstanding <= '0;
    end else begin
      r_free <= w_free_nxt;
      case ({w_req_fire, w_rel})
        2'b10:   outstanding <= outstanding + (ID_BITS+1)'(1);
        2'b01:   outstanding <= outstanding - (ID_BITS+1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Requester table: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_nid_tbl[w_alloc_id]  <= req_nid;
      r_l2id_tbl[w_alloc_id] <= req_l2id;
    end
  end

  // Single-entry request output register with pass-through refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drtomem_req_valid <= 1'b0;
      drtomem_req_paddr <= '0;
      drtomem_req_cmd   <= '0;
      drtomem_req_drid  <= '0;
    end else if (w_req_fire) begin
      drtomem_req_valid <= 1'b1;
      drtomem_req_paddr <= req_paddr;
      drtomem_req_cmd   <= req_cmd;
      drtomem_req_drid  <= w_alloc_id;
    end else if (!drtomem_req_retry) begin
      drtomem_req_valid <= 1'b0;
    end
  end

  // Single-entry snack output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drtol2_snack_valid <= 1'b0;
      drtol2_snack_nid   <= '0;
      drtol2_snack_l2id  <= '0;
      drtol2_snack_snack <= '0;
      drtol2_snack_line  <= '0;
    end else if (w_rel) begin
      drtol2_snack_valid <= 1'b1;
      drtol2_snack_nid   <= r_nid_tbl[memtodr_ack_drid];
      drtol2_snack_l2id  <= r_l2id_tbl[memtodr_ack_drid];
      drtol2_snack_snack <= memtodr_ack_ack;
      drtol2_snack_line  <= memtodr_ack_line;
    end else if (!drtol2_snack_retry) begin
      drtol2_snack_valid <= 1'b0;
    end
  end

`ifdef DR_TRACKER_ERRCHK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_spurious_ack <= 1'b0;
    end else if (w_ack_fire && !w_ack_legal) begin
      err_spurious_ack <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dr_memreq_tracker.sv
// Directed self-checking bench for dr_memreq_tracker (build with +define+DR_TRACKER_ERRCHK_EN
// to also exercise the spurious-ack checker).
module tb_dr_memreq_tracker;

  localparam int unsigned ID_BITS = 6;
  localparam int unsigned PADDR_W = 49;
  localparam int unsigned CMD_W   = 3;
  localparam int unsigned NID_W   = 5;
  localparam int unsigned L2ID_W  = 6;
  localparam int unsigned SNACK_W = 5;
  localparam int unsigned LINE_W  = 512;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_retry;
  logic [PADDR_W-1:0] req_paddr;
  logic [CMD_W-1:0]   req_cmd;
  logic [NID_W-1:0]   req_nid;
  logic [L2ID_W-1:0]  req_l2id;
  logic               drtomem_req_valid;
  logic               drtomem_req_retry;
  logic [PADDR_W-1:0] drtomem_req_paddr;
  logic [CMD_W-1:0]   drtomem_req_cmd;
  logic [ID_BITS-1:0] drtomem_req_drid;
  logic               memtodr_ack_valid;
  logic               memtodr_ack_retry;
  logic [ID_BITS-1:0] memtodr_ack_drid;
  logic [SNACK_W-1:0] memtodr_ack_ack;
  logic [LINE_W-1:0]  memtodr_ack_line;
  logic               drtol2_snack_valid;
  logic               drtol2_snack_retry;
  logic [NID_W-1:0]   drtol2_snack_nid;
  logic [L2ID_W-1:0]  drtol2_snack_l2id;
  logic [ID_BITS-1:0] drtol2_snack_drid;
  logic [SNACK_W-1:0] drtol2_snack_snack;
  logic [LINE_W-1:0]  drtol2_snack_line;
  logic [ID_BITS:0]   outstanding;
`ifdef DR_TRACKER_ERRCHK_EN
  logic               err_spurious_ack;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dr_memreq_tracker dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_retry          (req_retry),
    .req_paddr          (req_paddr),
    .req_cmd            (req_cmd),
    .req_nid            (req_nid),
    .req_l2id           (req_l2id),
    .drtomem_req_valid  (drtomem_req_valid),
    .drtomem_req_retry  (drtomem_req_retry),
    .drtomem_req_paddr  (drtomem_req_paddr),
    .drtomem_req_cmd    (drtomem_req_cmd),
    .drtomem_req_drid   (drtomem_req_drid),
    .memtodr_ack_valid  (memtodr_ack_valid),
    .memtodr_ack_retry  (memtodr_ack_retry),
    .memtodr_ack_drid   (memtodr_ack_drid),
    .memtodr_ack_ack    (memtodr_ack_ack),
    .memtodr_ack_line   (memtodr_ack_line),
    .drtol2_snack_valid (drtol2_snack_valid),
    .drtol2_snack_retry (drtol2_snack_retry),
    .drtol2_snack_nid   (drtol2_snack_nid),
    .drtol2_snack_l2id  (drtol2_snack_l2id),
    .drtol2_snack_drid  (drtol2_snack_drid),
    .drtol2_snack_snack (drtol2_snack_snack),
    .drtol2_snack_line  (drtol2_snack_line),
    .outstanding        (outstanding)
`ifdef DR_TRACKER_ERRCHK_EN
    ,
    .err_spurious_ack   (err_spurious_ack)
`endif
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [NID_W-1:0] nid, input logic [L2ID_W-1:0] l2id,
                         input logic [PADDR_W-1:0] paddr, input logic [CMD_W-1:0] cmd);
    req_valid = v;
    req_nid   = nid;
    req_l2id  = l2id;
    req_paddr = paddr;
    req_cmd   = cmd;
  endtask

  task automatic set_ack(input logic v, input logic [ID_BITS-1:0] drid, input logic [SNACK_W-1:0] code,
                         input logic [LINE_W-1:0] line);
    memtodr_ack_valid = v;
    memtodr_ack_drid  = drid;
    memtodr_ack_ack   = code;
    memtodr_ack_line  = line;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(1'b0, '0, '0, '0, '0);
    set_ack(1'b0, '0, '0, '0);
    drtomem_req_retry  = 1'b0;
    drtol2_snack_retry = 1'b0;
    repeat (3) tick();
    checks++; if (drtomem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %0b exp 0", drtomem_req_valid); end
    checks++; if (drtol2_snack_valid !== 1'b0) begin errors++; $display("FAIL rst_snack_valid got %0b exp 0", drtol2_snack_valid); end
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    checks++; if (drtomem_req_drid !== 6'd0) begin errors++; $display("FAIL rst_mem_drid got %0d exp 0", drtomem_req_drid); end
    checks++; if (drtol2_snack_line !== '0) begin errors++; $display("FAIL rst_snack_line got %0h exp 0", drtol2_snack_line); end
`ifdef DR_TRACKER_ERRCHK_EN
    checks++; if (err_spurious_ack !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_spurious_ack); end
`endif
    reset = 1'b1;
    tick();
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL rst_req_retry got %0b exp 0", req_retry); end
    checks++; if (memtodr_ack_retry !== 1'b0) begin errors++; $display("FAIL rst_ack_retry got %0b exp 0", memtodr_ack_retry); end
  endtask

  task automatic test_alloc_order();
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, NID_W'(k + 1), L2ID_W'(k + 10), PADDR_W'(32'h1000 + k), CMD_W'(k + 1));
      tick();
      checks++; if (drtomem_req_valid !== 1'b1 || drtomem_req_drid !== ID_BITS'(k + 1))
        begin errors++; $display("FAIL alloc_drid%0d got v=%0b drid=%0d exp v=1 drid=%0d", k, drtomem_req_valid, drtomem_req_drid, k + 1); end
      checks++; if (drtomem_req_paddr !== PADDR_W'(32'h1000 + k) || drtomem_req_cmd !== CMD_W'(k + 1))
        begin errors++; $display("FAIL alloc_payload%0d got %0h/%0d exp %0h/%0d", k, drtomem_req_paddr, drtomem_req_cmd, 32'h1000 + k, k + 1); end
    end
    set_req(1'b0, '0, '0, '0, '0);
    checks++; if (outstanding !== 7'd3) begin errors++; $display("FAIL alloc_outstanding got %0d exp 3", outstanding); end
    tick();
    checks++; if (drtomem_req_valid !== 1'b0) begin errors++; $display("FAIL alloc_drain got %0b exp 0", drtomem_req_valid); end
  endtask

  task automatic test_ooo_acks();
    logic [ID_BITS-1:0] ids  [3] = '{6'd3, 6'd1, 6'd2};
    logic [NID_W-1:0]   nids [3] = '{5'd3, 5'd1, 5'd2};
    logic [L2ID_W-1:0]  l2s  [3] = '{6'd12, 6'd10, 6'd11};
    for (int k = 0; k < 3; k++) begin
      set_ack(1'b1, ids[k], SNACK_W'(k + 4), LINE_W'(k + 100));
      #1;
      checks++; if (memtodr_ack_retry !== 1'b0) begin errors++; $display("FAIL ooo_ack_retry%0d got %0b exp 0", k, memtodr_ack_retry); end
      tick();
      checks++; if (drtol2_snack_valid !== 1'b1 || drtol2_snack_nid !== nids[k] || drtol2_snack_l2id !== l2s[k])
        begin errors++; $display("FAIL ooo_snack%0d got v=%0b nid=%0d l2id=%0d exp v=1 nid=%0d l2id=%0d", k, drtol2_snack_valid, drtol2_snack_nid, drtol2_snack_l2id, nids[k], l2s[k]); end
      checks++; if (drtol2_snack_drid !== 6'd0 || drtol2_snack_snack !== SNACK_W'(k + 4) || drtol2_snack_line !== LINE_W'(k + 100))
        begin errors++; $display("FAIL ooo_passthru%0d got drid=%0d code=%0d line=%0h exp 0/%0d/%0h", k, drtol2_snack_drid, drtol2_snack_snack, drtol2_snack_line, k + 4, k + 100); end
    end
    set_ack(1'b0, '0, '0, '0);
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL ooo_outstanding got %0d exp 0", outstanding); end
    tick();
    checks++; if (drtol2_snack_valid !== 1'b0) begin errors++; $display("FAIL ooo_snack_drain got %0b exp 0", drtol2_snack_valid); end
    set_req(1'b1, 5'd4, 6'd20, PADDR_W'(32'h2000), 3'd1);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    checks++; if (drtomem_req_drid !== 6'd1) begin errors++; $display("FAIL ooo_realloc got %0d exp 1", drtomem_req_drid); end
    set_ack(1'b1, 6'd1, '0, '0);
    tick();
    set_ack(1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_full();
    int bad = 0;
    for (int i = 0; i < 63; i++) begin
      set_req(1'b1, NID_W'(i), L2ID_W'(i), PADDR_W'(i), CMD_W'(i));
      tick();
      checks++; if (drtomem_req_drid !== ID_BITS'(i + 1))
        begin errors++; bad++; if (bad < 4) $display("FAIL full_drid%0d got %0d exp %0d", i, drtomem_req_drid, i + 1); end
    end
    set_req(1'b1, 5'd7, 6'd33, PADDR_W'(32'hABC), 3'd5);
    #1;
    checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL full_retry got %0b exp 1", req_retry); end
    checks++; if (outstanding !== 7'd63) begin errors++; $display("FAIL full_outstanding got %0d exp 63", outstanding); end
    tick();
    checks++; if (drtomem_req_valid !== 1'b0 || req_retry !== 1'b1)
      begin errors++; $display("FAIL full_hold got v=%0b retry=%0b exp 0/1", drtomem_req_valid, req_retry); end
    set_ack(1'b1, 6'd17, 5'd2, '0);
    tick();
    set_ack(1'b0, '0, '0, '0);
    #1;
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL full_freed_retry got %0b exp 0", req_retry); end
    checks++; if (drtol2_snack_valid !== 1'b1 || drtol2_snack_nid !== 5'd16 || drtol2_snack_l2id !== 6'd16)
      begin errors++; $display("FAIL full_snack got v=%0b nid=%0d l2id=%0d exp 1/16/16", drtol2_snack_valid, drtol2_snack_nid, drtol2_snack_l2id); end
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    checks++; if (drtomem_req_valid !== 1'b1 || drtomem_req_drid !== 6'd17 || drtomem_req_paddr !== PADDR_W'(32'hABC))
      begin errors++; $display("FAIL full_reissue got v=%0b drid=%0d paddr=%0h exp 1/17/abc", drtomem_req_valid, drtomem_req_drid, drtomem_req_paddr); end
    checks++; if (outstanding !== 7'd63) begin errors++; $display("FAIL full_outstanding2 got %0d exp 63", outstanding); end
    for (int d = 1; d < 64; d++) begin
      set_ack(1'b1, ID_BITS'(d), '0, '0);
      tick();
    end
    set_ack(1'b0, '0, '0, '0);
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", outstanding); end
    tick();
  endtask

  task automatic test_mem_backpressure();
    drtomem_req_retry = 1'b1;
    set_req(1'b1, 5'd1, 6'd1, PADDR_W'(32'h5A5A), 3'd2);
    tick();
    set_req(1'b1, 5'd2, 6'd2, PADDR_W'(32'h6B6B), 3'd3);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_retry !== 1'b1) begin errors++; $display("FAIL bp_retry%0d got %0b exp 1", c, req_retry); end
      checks++; if (drtomem_req_valid !== 1'b1 || drtomem_req_drid !== 6'd1 || drtomem_req_paddr !== PADDR_W'(32'h5A5A) || drtomem_req_cmd !== 3'd2)
        begin errors++; $display("FAIL bp_stable%0d got v=%0b drid=%0d paddr=%0h exp 1/1/5a5a", c, drtomem_req_valid, drtomem_req_drid, drtomem_req_paddr); end
      tick();
    end
    drtomem_req_retry = 1'b0;
    #1;
    checks++; if (req_retry !== 1'b0) begin errors++; $display("FAIL bp_release got %0b exp 0", req_retry); end
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    checks++; if (drtomem_req_valid !== 1'b1 || drtomem_req_drid !== 6'd2 || drtomem_req_paddr !== PADDR_W'(32'h6B6B))
      begin errors++; $display("FAIL bp_second got v=%0b drid=%0d paddr=%0h exp 1/2/6b6b", drtomem_req_valid, drtomem_req_drid, drtomem_req_paddr); end
    tick();
    checks++; if (drtomem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", drtomem_req_valid); end
    for (int d = 1; d < 3; d++) begin
      set_ack(1'b1, ID_BITS'(d), '0, '0);
      tick();
    end
    set_ack(1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_snack_backpressure();
    logic [LINE_W-1:0] a5_line;
    a5_line = {64{8'hA5}};
    set_req(1'b1, 5'd9, 6'd40, PADDR_W'(32'h100), 3'd1);
    tick();
    set_req(1'b1, 5'd10, 6'd41, PADDR_W'(32'h200), 3'd1);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    drtol2_snack_retry = 1'b1;
    set_ack(1'b1, 6'd1, 5'd3, a5_line);
    tick();
    set_ack(1'b1, 6'd2, 5'd6, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (memtodr_ack_retry !== 1'b1) begin errors++; $display("FAIL sbp_ack_retry%0d got %0b exp 1", c, memtodr_ack_retry); end
      checks++; if (outstanding !== 7'd1) begin errors++; $display("FAIL sbp_outstanding%0d got %0d exp 1", c, outstanding); end
      checks++; if (drtol2_snack_valid !== 1'b1 || drtol2_snack_nid !== 5'd9 || drtol2_snack_l2id !== 6'd40 || drtol2_snack_line !== a5_line)
        begin errors++; $display("FAIL sbp_stable%0d got v=%0b nid=%0d l2id=%0d line_ok=%0b exp 1/9/40/1", c, drtol2_snack_valid, drtol2_snack_nid, drtol2_snack_l2id, drtol2_snack_line === a5_line); end
      tick();
    end
    drtol2_snack_retry = 1'b0;
    #1;
    checks++; if (memtodr_ack_retry !== 1'b0) begin errors++; $display("FAIL sbp_release got %0b exp 0", memtodr_ack_retry); end
    tick();
    set_ack(1'b0, '0, '0, '0);
    checks++; if (drtol2_snack_valid !== 1'b1 || drtol2_snack_nid !== 5'd10 || drtol2_snack_snack !== 5'd6)
      begin errors++; $display("FAIL sbp_second got v=%0b nid=%0d code=%0d exp 1/10/6", drtol2_snack_valid, drtol2_snack_nid, drtol2_snack_snack); end
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL sbp_outstanding_end got %0d exp 0", outstanding); end
    tick();
  endtask

`ifdef DR_TRACKER_ERRCHK_EN
  task automatic test_spurious();
    set_req(1'b1, 5'd1, 6'd1, PADDR_W'(32'h300), 3'd1);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    tick();
    set_ack(1'b1, 6'd5, 5'd1, '0);
    tick();
    set_ack(1'b0, '0, '0, '0);
    checks++; if (err_spurious_ack !== 1'b1) begin errors++; $display("FAIL spur_err got %0b exp 1", err_spurious_ack); end
    checks++; if (drtol2_snack_valid !== 1'b0) begin errors++; $display("FAIL spur_snack got %0b exp 0", drtol2_snack_valid); end
    checks++; if (outstanding !== 7'd1) begin errors++; $display("FAIL spur_outstanding got %0d exp 1", outstanding); end
    set_req(1'b1, 5'd2, 6'd2, PADDR_W'(32'h400), 3'd1);
    tick();
    set_req(1'b0, '0, '0, '0, '0);
    checks++; if (drtomem_req_drid !== 6'd2) begin errors++; $display("FAIL spur_next_drid got %0d exp 2", drtomem_req_drid); end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc_order();
    test_ooo_acks();
    test_full();
    test_mem_backpressure();
    test_snack_backpressure();
`ifdef DR_TRACKER_ERRCHK_EN
    test_spurious();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
